// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory bus between instruction fetch and
// data access; bounds fetch starvation and aborts transactions on a hung bus.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err,
  output logic        owner,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req (and its payload) until it sees a one-cycle ack; the req
  // still visible during the ack cycle belongs to the finished transaction and is never granted.
  // On the bus side mem_* stay stable from grant until the beat in which mem_ready=1.
  typedef enum logic [1:0] {IDLE = 2'd0, BUS_IF = 2'd1, BUS_D = 2'd2} state_t;

  localparam int               SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]       TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [2:0]       IF_OP      = 3'b010;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [2:0]    mem_op_q, mem_op_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          if_ack_q, if_ack_d, d_ack_q, d_ack_d, bus_err_q, bus_err_d;
  logic          owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [7:0]    tmo_q, tmo_d;

  logic if_elig, d_elig, grant_if, grant_d, done, timed_out;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;
    owner_d     = owner_q;
    tmo_d       = tmo_q;
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    done        = 1'b0;
    timed_out   = 1'b0;
    if_elig     = if_req & ~if_ack_q;
    d_elig      = d_req & ~d_ack_q;

    case (state_q)
      IDLE: begin
        if (d_elig && !(if_elig && streak_q >= STREAK_MAX)) grant_d = 1'b1;
        else if (if_elig)                                    grant_if = 1'b1;
        if (grant_d) begin
          state_d     = BUS_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_op_d    = d_op;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          owner_d     = 1'b1;
          tmo_d       = 8'd0;
        end else if (grant_if) begin
          state_d     = BUS_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_op_d    = IF_OP;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'd0;
          owner_d     = 1'b0;
          tmo_d       = 8'd0;
        end
      end
      BUS_IF, BUS_D: begin
        if (mem_ready || tmo_q == TMO_LAST) done = 1'b1;
        else                                tmo_d = tmo_q + 8'd1;
        if (done) begin
          // A timed-out beat completes like a normal one, but with zero data and bus_err.
          timed_out = ~mem_ready;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          bus_err_d = timed_out;
          if (state_q == BUS_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = timed_out ? 32'd0 : mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = timed_out ? 32'd0 : mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!if_req || grant_if)                    streak_d = '0;
    else if (grant_d && streak_q < STREAK_MAX)  streak_d = streak_q + SW'(1);
    else                                        streak_d = streak_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_op_q    <= 3'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      owner_q     <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      bus_err_q   <= bus_err_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_op    = mem_op_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign bus_err   = bus_err_q;
  assign owner     = owner_q;
  assign dbg_state = state_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = d_req & ~d_ack_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency memory bus between the instruction-fetch port (IF) and the data-access port (MEM stage) of the 5-stage pipeline.
- Sequences each transaction with a request/ack handshake and drives the stall requests that the pipeline status controller turns into PAUSE.
- Bounds starvation of fetch and times out a hung memory.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants while if_req is pending before IF is forced.
- TIMEOUT, 64: cycles in a bus state without mem_ready before the transaction is aborted (1..255).

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word, valid with if_ack
- if_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store
- d_op  in  3  memop code, passed through
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid with d_ack
- d_ack  out  1  one-cycle completion pulse
- mem_req  out  1  bus request to memory
- mem_we  out  1  bus write enable
- mem_op  out  3  bus memop
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_rdata  in  32  bus read data
- mem_ready  in  1  memory completes current beat
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_mem  out  1  d_req & ~d_ack (combinational)
- bus_err  out  1  pulses with ack on timeout
- owner  out  1  0 = IF, 1 = data (debug; last grant)

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE; all registered outputs 0, including mem_req, mem_we, mem_op, mem_addr, mem_wdata, *_rdata, *_ack, bus_err, owner; streak and timeout counters cleared. A transaction in flight is dropped with no ack.
- States:
  - IDLE: on a request, latch the winner's addr/op/we/wdata into mem_* and set mem_req=1. Go to BUS_IF or BUS_D.
  - BUS_IF / BUS_D: mem_* held stable. When mem_ready=1, capture mem_rdata into the owner's rdata, pulse the owner's ack for exactly 1 cycle, and return to IDLE with mem_req=0.
  - Timeout: on the TIMEOUT-th consecutive cycle without mem_ready, exit as if ready, with rdata=0 and bus_err=1 for the ack cycle.
- Arbitration in IDLE:
  - Data wins over IF unless if_req=1 and streak>=STARVE_LIMIT; then IF wins.
  - streak increments on each data grant while if_req=1, saturates at STARVE_LIMIT, and clears on an IF grant or whenever if_req=0.
- Ack-cycle rule: in the IDLE cycle where X_ack=1, port X's req is ignored, because it belongs to the completed transaction. The other port may be granted in that same cycle.
- Stores: mem_we=1; d_ack pulses on mem_ready; d_rdata unchanged.
- Latency: request seen in IDLE at edge k puts mem_req high after k. mem_ready sampled at edge k+n puts ack high during cycle k+n+1. Zero-wait minimum is ack 2 cycles after req.
- Simultaneous if_req and d_req with streak<LIMIT: data is served first, then IF in the data ack cycle.
- mem_ready while in IDLE is ignored.
- The timeout counter resets on every grant.
- owner holds its value through IDLE.

Test Plan:
- Reset mid-transaction: d_req with mem_ready held 0, assert clr=0 at cycle 3 → mem_req=0 immediately, no d_ack. After release, IDLE accepts a new req.
- Zero-wait fetch: if_req, if_addr=0x100, mem_ready=1, mem_rdata=0x00500093 → mem_addr=0x100 in cycle 1; if_ack=1 with if_rdata=0x00500093 in cycle 2; stall_if high cycles 0–1.
- Contention: if_req and d_req together, d_we=1, d_addr=0x2000, d_wdata=0xCAFEF00D → store granted first with mem_we=1; IF granted in the d_ack cycle; owner sequence 1→0.
- Starvation: if_req held, d_req re-asserted continuously, STARVE_LIMIT=4 → exactly 4 data grants, then an IF grant, then streak=0.
- Timeout: d_req load, mem_ready never asserted, TIMEOUT=64 → d_ack and bus_err pulse together after 64 bus cycles, d_rdata=0, mem_req drops.
- Wait states: mem_ready asserted after 5 cycles → mem_addr/op/wdata stable all 5 cycles; a single ack; no regrant of the same req in the ack cycle.
